// File: rtl/keypad_event_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and constants for the keypad event scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int KEY_NUM    = 16;
    localparam int KEY_CODE_W = 4;
    localparam int REP_CNT_W  = 24;
    localparam int EVT_W      = KEY_CODE_W + 1;

    typedef struct packed {
        logic                  rpt;
        logic [KEY_CODE_W-1:0] code;
    } evt_t;

    typedef enum logic [1:0] {
        REP_IDLE  = 2'd0,
        REP_DELAY = 2'd1,
        REP_RUN   = 2'd2
    } rep_state_e;

    // Returns {found, index} of the first set request at or after start,
    // wrapping from the top key back to key 0.
    function automatic logic [KEY_CODE_W:0] rr_search(
        input logic [KEY_NUM-1:0]    req,
        input logic [KEY_CODE_W-1:0] start
    );
        logic [KEY_CODE_W:0]   res;
        logic [KEY_CODE_W-1:0] idx;
        res = '0;
        for (int k = KEY_NUM - 1; k >= 0; k--) begin
            idx = start + KEY_CODE_W'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_event_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_event_scheduler_if
// Description : Valid/ready key-event stream from scheduler to consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_event_scheduler_if;
    import keypad_pkg::*;

    logic                  evt_valid;
    logic                  evt_ready;
    logic [KEY_CODE_W-1:0] evt_code;
    logic                  evt_repeat;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_repeat,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_repeat,
        output evt_ready
    );

endinterface
`default_nettype wire

// File: rtl/keypad_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : keypad_evt_fifo
// Description : Synchronous event FIFO, power-of-two depth, no bypass path.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_evt_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = EVT_W
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int             c_aw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_aw:0]  c_full = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full  = (r_count == c_full);
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_aw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_aw + 1)'(1);
                2'b01:   r_count <= r_count - (c_aw + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : keypad_event_scheduler
// Description : Round-robin key-press serialiser with auto-repeat and event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_event_scheduler
    import keypad_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 6_000_000,
    parameter int REPEAT_RATE  = 1_200_000
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [KEY_NUM-1:0]        key_out,
    input  logic [KEY_NUM-1:0]        key_pulse,
    keypad_event_scheduler_if.master  evt,
    output logic                      overflow,
    input  logic                      ovf_clr
);

    localparam logic [REP_CNT_W-1:0] c_delay_ld = REP_CNT_W'(REPEAT_DELAY - 1);
    localparam logic [REP_CNT_W-1:0] c_rate_ld  = REP_CNT_W'(REPEAT_RATE - 1);

    logic [KEY_NUM-1:0]    r_pend;
    logic [KEY_CODE_W-1:0] r_ptr;
    logic                  r_ovf;

    rep_state_e            r_state;
    rep_state_e            w_state_nxt;
    logic [REP_CNT_W-1:0]  r_cnt;
    logic [REP_CNT_W-1:0]  w_cnt_nxt;
    logic [KEY_CODE_W-1:0] r_rep_key;
    logic [KEY_CODE_W-1:0] w_rep_key_nxt;
    logic                  r_rep_pend;
    logic                  w_rep_pend_nxt;
    logic                  w_rep_ovf;

    logic                  w_full;
    logic                  w_empty;
    logic [EVT_W-1:0]      w_head_bits;
    evt_t                  w_head;
    evt_t                  w_push_evt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_space;

    logic [KEY_CODE_W:0]   w_rr;
    logic                  w_found;
    logic [KEY_CODE_W-1:0] w_gidx;
    logic                  w_key_grant;
    logic                  w_rep_grant;
    logic [KEY_NUM-1:0]    w_gmask;
    logic                  w_pend_ovf;

    // ------------------------------------------------------------------
    // Arbitration: fresh presses first, repeat only when no press waits
    // ------------------------------------------------------------------
    assign w_pop       = !w_empty && evt.evt_ready;
    assign w_space     = !w_full || w_pop;

    assign w_rr        = rr_search(r_pend, r_ptr);
    assign w_found     = w_rr[KEY_CODE_W];
    assign w_gidx      = w_rr[KEY_CODE_W-1:0];

    assign w_key_grant = w_found && w_space;
    assign w_rep_grant = r_rep_pend && (r_pend == '0) && w_space;
    assign w_gmask     = w_key_grant ? (KEY_NUM'(1) << w_gidx) : '0;
    assign w_push      = w_key_grant || w_rep_grant;

    // A pulse landing on a still-pending, ungranted key merges into one event.
    assign w_pend_ovf  = |(key_pulse & r_pend & ~w_gmask);

    always_comb begin
        w_push_evt = '0;
        if (w_key_grant) begin
            w_push_evt.rpt  = 1'b0;
            w_push_evt.code = w_gidx;
        end else begin
            w_push_evt.rpt  = 1'b1;
            w_push_evt.code = r_rep_key;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_ptr  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_gmask) | key_pulse;
            if (w_key_grant) begin
                r_ptr <= w_gidx + KEY_CODE_W'(1);
            end
            if (w_pend_ovf || w_rep_ovf) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Auto-repeat FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= REP_IDLE;
            r_cnt      <= '0;
            r_rep_key  <= '0;
            r_rep_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rep_key  <= w_rep_key_nxt;
            r_rep_pend <= w_rep_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rep_key_nxt  = r_rep_key;
        w_rep_pend_nxt = r_rep_pend && !w_rep_grant;
        w_rep_ovf      = 1'b0;

        if (w_key_grant) begin
            // Every fresh press retargets the repeater, even mid-run.
            w_rep_key_nxt  = w_gidx;
            w_cnt_nxt      = c_delay_ld;
            w_state_nxt    = REP_DELAY;
            w_rep_pend_nxt = 1'b0;
        end else begin
            case (r_state)
                REP_DELAY, REP_RUN: begin
                    if (key_out[r_rep_key]) begin
                        w_state_nxt    = REP_IDLE;
                        w_rep_pend_nxt = 1'b0;
                    end else if (r_cnt == '0) begin
                        if (r_rep_pend && !w_rep_grant) begin
                            w_rep_ovf = 1'b1;
                        end
                        w_rep_pend_nxt = 1'b1;
                        w_cnt_nxt      = c_rate_ld;
                        w_state_nxt    = REP_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - REP_CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = REP_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Event queue
    // ------------------------------------------------------------------
    keypad_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_evt),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head_bits)
    );

    assign w_head         = evt_t'(w_head_bits);
    assign evt.evt_valid  = !w_empty;
    assign evt.evt_code   = w_head.code;
    assign evt.evt_repeat = w_head.rpt;
    assign overflow       = r_ovf;

endmodule
`default_nettype wire
